// File: rtl/bsg_dispatch_pkg.sv
// Shared types for the two-level round-robin dispatcher.
package bsg_dispatch_pkg;

    localparam int unsigned dispatch_width_gp = 3;

    function automatic int unsigned idx_width(input int unsigned w);
        return (w > 1) ? $clog2(w) : 1;
    endfunction

    typedef logic [idx_width(dispatch_width_gp)-1:0] chan_idx_t;

    typedef enum logic {
        e_level_low  = 1'b0,
        e_level_high = 1'b1
    } level_e;

endpackage

// File: rtl/bsg_dispatch_rr_pick.sv
// Round-robin picker over one group's empty slots.
// The pick is combinational; a thermometer mask holds the last pick.
module bsg_dispatch_rr_pick #(
    parameter int unsigned width_p = 3
) (
    input  logic               clk_i,
    input  logic               reset_n_i,
    input  logic [width_p-1:0] empty_i,
    input  logic               take_i,
    output logic [width_p-1:0] pick_c_o,
    output logic               any_empty_c_o
);

    localparam int unsigned w_lp = width_p;

    logic [w_lp-1:0] mask_q, mask_d, masked;

    function automatic logic [w_lp-1:0] lowest_set(input logic [w_lp-1:0] x);
        return x & (~x + w_lp'(1));
    endfunction

    // Mask holds the slots strictly above the last pick, so the scan resumes there.
    always_comb begin
        masked        = empty_i & mask_q;
        any_empty_c_o = |empty_i;
        pick_c_o      = (masked != '0) ? lowest_set(masked) : lowest_set(empty_i);
        mask_d        = mask_q;
        if (take_i) begin
            mask_d = ~(pick_c_o | (pick_c_o - w_lp'(1)));
        end
    end

    // All-zero mask == pointer at the last index, so the first pick is index 0.
    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            mask_q <= '0;
        end else begin
            mask_q <= mask_d;
        end
    end

endmodule

// File: rtl/bsg_dispatch_round_robin_two_level.sv
// Fans one valid/ready stream out to 2*width_p one-entry channel registers,
// preferring the high group and serving each group round-robin.
module bsg_dispatch_round_robin_two_level
    import bsg_dispatch_pkg::*;
#(
    parameter int unsigned width_p      = 3,
    parameter int unsigned data_width_p = 8
) (
    input  logic                                clk_i,
    input  logic                                reset_n_i,
    input  logic                                v_i,
    input  logic [data_width_p-1:0]             data_i,
    output logic                                ready_o,
    output logic [2*width_p-1:0]                v_o,
    output logic [2*width_p*data_width_p-1:0]   data_o,
    input  logic [2*width_p-1:0]                yumi_i,
    output logic                                dispatched_high_o
);

    localparam int unsigned chan_lp = 2 * width_p;

    logic [chan_lp-1:0]                    v_q, v_d, empty, load;
    logic [chan_lp-1:0][data_width_p-1:0]  data_q;
    logic                                  dhi_q, dhi_d;
    logic [width_p-1:0]                    pick_lo, pick_hi;
    logic                                  any_lo, any_hi;
    logic                                  accept, take_lo, take_hi;
    level_e                                level;

    assign empty   = ~v_q;
    assign ready_o = any_hi | any_lo;
    assign accept  = v_i & ready_o;
    assign level   = any_hi ? e_level_high : e_level_low;
    assign take_hi = accept & (level == e_level_high);
    assign take_lo = accept & (level == e_level_low);

    bsg_dispatch_rr_pick #(.width_p(width_p)) u_pick_lo (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .empty_i       (empty[width_p-1:0]),
        .take_i        (take_lo),
        .pick_c_o      (pick_lo),
        .any_empty_c_o (any_lo)
    );

    bsg_dispatch_rr_pick #(.width_p(width_p)) u_pick_hi (
        .clk_i         (clk_i),
        .reset_n_i     (reset_n_i),
        .empty_i       (empty[chan_lp-1:width_p]),
        .take_i        (take_hi),
        .pick_c_o      (pick_hi),
        .any_empty_c_o (any_hi)
    );

    // Loaded slots are always empty at cycle start, so they never collide with a drain.
    always_comb begin
        load  = '0;
        dhi_d = dhi_q;
        if (take_hi) begin
            load[chan_lp-1:width_p] = pick_hi;
        end
        if (take_lo) begin
            load[width_p-1:0] = pick_lo;
        end
        v_d = (v_q & ~yumi_i) | load;
        if (accept) begin
            dhi_d = (level == e_level_high);
        end
    end

    always_ff @(posedge clk_i or negedge reset_n_i) begin
        if (!reset_n_i) begin
            v_q   <= '0;
            dhi_q <= 1'b0;
        end else begin
            v_q   <= v_d;
            dhi_q <= dhi_d;
        end
    end

    // Payload needs no reset; it is only observed while the slot is valid.
    always_ff @(posedge clk_i) begin
        for (int unsigned k = 0; k < chan_lp; k++) begin
            if (load[k]) begin
                data_q[k] <= data_i;
            end
        end
    end

    assign v_o               = v_q;
    assign data_o            = data_q;
    assign dispatched_high_o = dhi_q;

    a_yumi_on_valid: assert property (@(posedge clk_i) disable iff (!reset_n_i)
        ((yumi_i & ~v_q) == '0));

endmodule

// File: doc/bsg_dispatch_round_robin_two_level.md
Name: bsg_dispatch_round_robin_two_level

Overview:
- Transmit-side counterpart of the two-level round-robin arbiter: fans one valid/ready input stream out to 2*width_p consumer channels instead of merging many requesters into one.
- Channels are split into a high group and a low group; the high group is preferred, and each group is served round-robin.
- Each channel has a one-entry output register that is drained by a consumer yumi.
- Sits in front of replicated engines, e.g. fast and slow worker pools.

Parameters:
- width_p, 3, channels per level; total channels = 2*width_p; width_p >= 1.
- data_width_p, 8, payload width.

Ports:
- clk_i  in  1  clock.
- reset_n_i  in  1  asynchronous, active-low reset.
- v_i  in  1  input valid.
- data_i  in  data_width_p  input payload.
- ready_o  out  1  input can be accepted this cycle.
- v_o  out  2*width_p  per-channel valid; bits [width_p-1:0] are low, [2*width_p-1:width_p] are high.
- data_o  out  2*width_p*data_width_p  per-channel payload; channel k at [k*data_width_p +: data_width_p].
- yumi_i  in  2*width_p  per-channel consume, legal only when the matching v_o bit is 1.
- dispatched_high_o  out  1  last accepted item went to the high group.

Behaviour:
- Reset is asynchronous, active-low; reset_n_i=0 takes effect immediately, without a clock edge:
  - v_o=0, dispatched_high_o=0.
  - Both round-robin pointers set to last index = width_p-1, so the first pick in each group is index 0.
  - data_o contents are don't-care.
- A slot is empty when its valid register is 0 at the start of the cycle.
  - A slot that is drained by yumi_i in a cycle is not eligible for a new item in that same cycle.
  - There is no same-cycle pass-through.
- ready_o = OR of empty over all slots; this is purely registered-state, with no combinational path from v_i or yumi_i.
- Accept = v_i & ready_o.
- Target selection (combinational, from the registered state):
  - If any high slot is empty, pick the first empty high slot scanning upward from (ptr_hi+1) mod width_p.
  - Otherwise pick the first empty low slot scanning upward from (ptr_lo+1) mod width_p.
- On accept, at the clock edge:
  - The target slot's valid is set to 1 and its data is loaded from data_i.
  - The pointer of the chosen group is set to the target index; the other group's pointer is unchanged.
  - dispatched_high_o is set to 1 if the target was high, 0 if low.
- With no accept, pointers and dispatched_high_o hold.
- Latency is 1 cycle: an item accepted in cycle t is visible on v_o/data_o in cycle t+1.
- yumi_i[k]=1 clears valid k at the edge. data_o[k] holds while valid and is not rewritten until the slot is re-filled.
- Simultaneous yumi_i on slot k and accept to a different slot: both take effect.
- A pick of slot k in the same cycle as yumi_i[k] cannot occur, because a slot being drained is not empty.
- yumi_i on an invalid slot is a protocol error: a simulation-only assertion fires, and the hardware ignores it (valid stays 0).
- v_i=1 while ready_o=0: nothing is accepted, and data_i is not sampled.
- Pointer wrap: the scan wraps from index width_p-1 back to 0.
- Selection state is held in a thermometer mask per group, as in the arbiter: mask = bits above the pointer.
  - The pick is the priority-encoded (empty & mask); if that is zero, the pick is the priority-encoded empty.

Decomposition:
- Shared package bsg_dispatch_pkg holds:
  - channel index typedef sized $clog2(width_p) (minimum 1 bit);
  - a level enum { e_level_low=0, e_level_high=1 }.
- Natural sub-module: bsg_dispatch_rr_pick, instantiated once per level.
  - Owns the pointer/thermocode register (async active-low reset).
  - Inputs: empty vector, take.
  - Outputs: one-hot pick, any_empty.
  - The top level holds the slot registers, level select, ready_o and dispatched_high_o.

Test Plan (width_p=3, data_width_p=8):
- Reset scenario: hold reset_n_i=0 and check v_o=000000, ready_o=1, dispatched_high_o=0. Drop reset_n_i mid-cycle with no clock edge and confirm v_o clears immediately.
- Fill order: push 8'hA0, A1, A2, A3 back-to-back with yumi_i=0.
  - v_o sequence: 001000, 011000, 111000, 111001.
  - data_o: ch3=A0, ch4=A1, ch5=A2, ch0=A3.
  - dispatched_high_o sequence: 1, 1, 1, 0.
- Full: fill all 6 slots and keep v_i=1. Expect ready_o=0, no slot data changes, and pointers unchanged.
- Refill after drain: with all 6 slots full and ptr_hi=2, pulse yumi_i=010000, then push 8'hB0. B0 lands in ch4 with v_o=111111, and ptr_hi becomes 1.
- Round-robin wrap: ptr_hi=2 with high slots 0 and 2 empty; push X then Y. X goes to ch3, Y goes to ch5 (pointer wraps).
- Same-cycle drain plus push: low-only empty slot ch1, plus yumi_i on ch5 in the same cycle as a push.
  - The item goes to ch1, not ch5.
  - Next cycle v_o[5]=0 and dispatched_high_o=0.
